// File: rtl/alu_share_ctrl.sv
// Shares one 4-bit ALU between two valid/ready requesters (round-robin or fixed priority).
// Accept -> result visible two cycles later; result held until rsp_ready, no accepts meanwhile.

module alu_4bit (
  input  logic [2:0] op_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] res_o,
  output logic       zero_o,
  output logic       overflow_o,
  output logic       carry_o
);
  logic [4:0] sum;
  logic [4:0] dif;

  assign sum = {1'b0, a_i} + {1'b0, b_i};
  assign dif = {1'b0, a_i} + {1'b0, ~b_i} + 5'd1;

  always_comb begin
    res_o      = 4'd0;
    zero_o     = 1'b0;
    overflow_o = 1'b0;
    carry_o    = 1'b0;
    case (op_i)
      3'b000: begin
        res_o      = sum[3:0];
        carry_o    = sum[4];
        overflow_o = (a_i[3] == b_i[3]) && (sum[3] != a_i[3]);
        zero_o     = (sum[3:0] == 4'd0);
      end
      3'b001: begin
        res_o      = dif[3:0];
        carry_o    = dif[4];
        overflow_o = (a_i[3] == ~b_i[3]) && (dif[3] != a_i[3]);
        zero_o     = (dif[3:0] == 4'd0);
      end
      3'b010:  res_o = ~a_i;
      3'b011:  res_o = a_i & b_i;
      3'b100:  res_o = a_i | b_i;
      3'b101:  res_o = a_i ^ b_i;
      3'b110:  res_o = (a_i < b_i) ? 4'd1 : 4'd0;
      default: res_o = (a_i == b_i) ? 4'd1 : 4'd0;
    endcase
  end
endmodule

module alu_share_ctrl #(
  parameter bit RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_res,
  output logic       rsp_zero,
  output logic       rsp_overflow,
  output logic       rsp_carry,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e     state_q, state_d;
  logic       last_grant_q;
  logic [2:0] op_q;
  logic [3:0] a_q, b_q;
  logic       id_q;
  logic       rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_overflow_q, rsp_carry_q;
  logic [3:0] rsp_res_q;

  logic       grant;
  logic       accept;
  logic [3:0] alu_res;
  logic       alu_zero, alu_overflow, alu_carry;

  // With no contention the lone valid requester wins; grant is only meaningful when accept is high.
  always_comb begin
    if (req0_valid && req1_valid) grant = RR ? ~last_grant_q : 1'b0;
    else                          grant = ~req0_valid;
  end

  assign accept     = (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q   <= 1'b1;
      op_q           <= 3'd0;
      a_q            <= 4'd0;
      b_q            <= 4'd0;
      id_q           <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_res_q      <= 4'd0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_carry_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q         <= grant ? req1_op : req0_op;
        a_q          <= grant ? req1_a  : req0_a;
        b_q          <= grant ? req1_b  : req0_b;
        id_q         <= grant;
        last_grant_q <= grant;
      end
      if (state_q == EXEC) begin
        rsp_valid_q    <= 1'b1;
        rsp_id_q       <= id_q;
        rsp_res_q      <= alu_res;
        rsp_zero_q     <= alu_zero;
        rsp_overflow_q <= alu_overflow;
        rsp_carry_q    <= alu_carry;
      end
      if (state_q == RESP && rsp_ready) rsp_valid_q <= 1'b0;
    end
  end

  // The ALU only ever sees the latched operands, so requesters may change inputs after accept.
  alu_4bit u_alu (
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .res_o      (alu_res),
    .zero_o     (alu_zero),
    .overflow_o (alu_overflow),
    .carry_o    (alu_carry)
  );

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_res      = rsp_res_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_carry    = rsp_carry_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: two instances (round-robin and fixed priority) on shared stimulus,
// checked every cycle against a transaction-level model plus directed literal expectations.

module tb_alu_share_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       r0v, r1v, rspr;
  logic [2:0] r0op, r1op;
  logic [3:0] r0a, r0b, r1a, r1b;
  logic [1:0] rdy0, rdy1, rv, rid, zf, of, cf, bz;
  logic [3:0] res [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.RR(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(rdy0[0]), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(rdy1[0]), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b),
    .rsp_valid(rv[0]), .rsp_ready(rspr), .rsp_id(rid[0]), .rsp_res(res[0]),
    .rsp_zero(zf[0]), .rsp_overflow(of[0]), .rsp_carry(cf[0]), .busy(bz[0])
  );

  alu_share_ctrl #(.RR(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(rdy0[1]), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(rdy1[1]), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b),
    .rsp_valid(rv[1]), .rsp_ready(rspr), .rsp_id(rid[1]), .rsp_res(res[1]),
    .rsp_zero(zf[1]), .rsp_overflow(of[1]), .rsp_carry(cf[1]), .busy(bz[1])
  );

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] res;
    logic       z;
    logic       o;
    logic       c;
  } alu_t;

  function automatic alu_t ref_alu(input int op, input int a, input int b);
    alu_t r;
    int sa, sb, s;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    r = '0;
    case (op)
      0: begin
        s = a + b;
        r.res = 4'(s % 16); r.c = (s > 15); r.o = (sa + sb > 7) || (sa + sb < -8); r.z = (s % 16 == 0);
      end
      1: begin
        s = (a - b + 16) % 16;
        r.res = 4'(s); r.c = (a >= b); r.o = (sa - sb > 7) || (sa - sb < -8); r.z = (s == 0);
      end
      2: r.res = 4'(15 - a);
      3: r.res = 4'(a & b);
      4: r.res = 4'(a | b);
      5: r.res = 4'(a ^ b);
      6: r.res = (a < b) ? 4'd1 : 4'd0;
      default: r.res = (a == b) ? 4'd1 : 4'd0;
    endcase
    return r;
  endfunction

  // Instance 0 is round-robin, instance 1 fixed priority.
  bit   model_ok = 1'b0;
  int   m_cnt [2];
  bit   m_last[2];
  bit   m_rv  [2];
  int   m_op[2], m_a[2], m_b[2], m_id[2], m_rid[2];
  alu_t m_r [2];

  function automatic bit m_idle(input int k);
    return (m_cnt[k] == 0) && !m_rv[k];
  endfunction

  function automatic int exp_grant(input int k);
    if (!r0v && !r1v) return -1;
    if (r0v && !r1v)  return 0;
    if (!r0v && r1v)  return 1;
    if (k == 0)       return m_last[k] ? 0 : 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) model_ok <= 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_cnt[k] <= 0; m_rv[k] <= 1'b0; m_r[k] <= '0; m_rid[k] <= 0; m_last[k] <= 1'b1;
      end else if (m_rv[k]) begin
        if (rspr) m_rv[k] <= 1'b0;
      end else if (m_cnt[k] == 1) begin
        m_r[k] <= ref_alu(m_op[k], m_a[k], m_b[k]);
        m_rid[k] <= m_id[k]; m_rv[k] <= 1'b1; m_cnt[k] <= 0;
      end else if (exp_grant(k) == 0) begin
        m_op[k] <= int'(r0op); m_a[k] <= int'(r0a); m_b[k] <= int'(r0b);
        m_id[k] <= 0; m_last[k] <= 1'b0; m_cnt[k] <= 1;
      end else if (exp_grant(k) == 1) begin
        m_op[k] <= int'(r1op); m_a[k] <= int'(r1a); m_b[k] <= int'(r1b);
        m_id[k] <= 1; m_last[k] <= 1'b1; m_cnt[k] <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d.req0_ready", k), 8'(rdy0[k]), 8'(m_idle(k) && exp_grant(k) == 0));
        chk($sformatf("u%0d.req1_ready", k), 8'(rdy1[k]), 8'(m_idle(k) && exp_grant(k) == 1));
        chk($sformatf("u%0d.busy", k),       8'(bz[k]),   8'(!m_idle(k)));
        chk($sformatf("u%0d.rsp_valid", k),  8'(rv[k]),   8'(m_rv[k]));
        chk($sformatf("u%0d.rsp_id", k),     8'(rid[k]),  8'(m_rid[k]));
        chk($sformatf("u%0d.rsp_res", k),    8'(res[k]),  8'(m_r[k].res));
        chk($sformatf("u%0d.rsp_zero", k),   8'(zf[k]),   8'(m_r[k].z));
        chk($sformatf("u%0d.rsp_ovf", k),    8'(of[k]),   8'(m_r[k].o));
        chk($sformatf("u%0d.rsp_carry", k),  8'(cf[k]),   8'(m_r[k].c));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  // Issues one op on the round-robin instance and checks the response against literals.
  task automatic run_op(input int req, input int op, input int a, input int b,
                        input int er, input int ec, input int eo, input int ez, input int hold);
    int n;
    logic [3:0] held;
    rspr = (hold == 0);
    if (req == 0) begin r0v = 1'b1; r0op = 3'(op); r0a = 4'(a); r0b = 4'(b); end
    else          begin r1v = 1'b1; r1op = 3'(op); r1a = 4'(a); r1b = 4'(b); end
    n = 0;
    @(negedge clk);
    while (!(req == 0 ? rdy0[0] : rdy1[0]) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      errors++; checks++;
      $display("FAIL accept_timeout: no ready for req%0d after %0d cycles", req, n);
      r0v = 1'b0; r1v = 1'b0; rspr = 1'b1;
      return;
    end
    step();
    // Scramble the requester's operands after accept; the result must use the latched ones.
    r0v = 1'b0; r1v = 1'b0;
    r0a = 4'($urandom); r0b = 4'($urandom); r1a = 4'($urandom); r1b = 4'($urandom);
    @(negedge clk);
    chk("exec.rsp_valid", 8'(rv[0]), 8'd0);
    chk("exec.busy", 8'(bz[0]), 8'd1);
    @(negedge clk);
    chk("lat.rsp_valid", 8'(rv[0]), 8'd1);
    chk("lit.id", 8'(rid[0]), 8'(req));
    chk("lit.res", 8'(res[0]), 8'(er));
    chk("lit.carry", 8'(cf[0]), 8'(ec));
    chk("lit.overflow", 8'(of[0]), 8'(eo));
    chk("lit.zero", 8'(zf[0]), 8'(ez));
    if (hold > 0) begin
      held = res[0];
      r1v = 1'b1;
      for (int i = 0; i < hold; i++) begin
        step();
        @(negedge clk);
        chk("hold.rsp_valid", 8'(rv[0]), 8'd1);
        chk("hold.res", 8'(res[0]), 8'(held));
        chk("hold.readys", 8'({rdy0[0], rdy1[0]}), 8'd0);
      end
      step(); rspr = 1'b1;
      @(negedge clk);
      chk("release.rsp_valid_pre", 8'(rv[0]), 8'd1);
      step();
      @(negedge clk);
      chk("release.rsp_valid", 8'(rv[0]), 8'd0);
      chk("release.busy", 8'(bz[0]), 8'd0);
      chk("release.waiter_ready", 8'(rdy1[0]), 8'd1);
      #2 r1v = 1'b0;
    end
    step();
  endtask

  // ---------------- main stimulus ----------------
  int grants[$];
  int gcyc[$];
  int n;

  initial begin
    rst = 1'b1; r0v = 1'b0; r1v = 1'b0; rspr = 1'b1;
    r0op = '0; r0a = '0; r0b = '0; r1op = '0; r1a = '0; r1b = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset.rsp_valid", 8'(rv[0]), 8'd0);
    chk("reset.busy", 8'(bz[0]), 8'd0);
    chk("reset.res", 8'(res[0]), 8'd0);
    step();

    run_op(0, 0, 7, 9, 0, 1, 0, 1, 0);
    run_op(1, 1, 3, 5, 14, 0, 0, 0, 0);
    run_op(1, 1, 5, 3, 2, 1, 0, 0, 0);
    run_op(1, 0, 4, 4, 8, 0, 1, 0, 0);
    run_op(0, 6, 2, 9, 1, 0, 0, 0, 4);
    run_op(0, 7, 6, 6, 1, 0, 0, 0, 0);

    // Both requesters saturated: RR alternates from 0, fixed priority starves requester 1.
    do_reset();
    rspr = 1'b1; r0v = 1'b1; r1v = 1'b1;
    for (int c = 0; c < 12; c++) begin
      r0op = 3'($urandom); r1op = 3'($urandom);
      @(negedge clk);
      if (rdy0[0] || rdy1[0]) begin grants.push_back(rdy1[0] ? 1 : 0); gcyc.push_back(c); end
      chk("fp.no_req1", 8'(rdy1[1]), 8'd0);
      step();
    end
    chk("rr.count", 8'(grants.size()), 8'd4);
    for (int i = 0; i < grants.size() && i < 4; i++) begin
      chk($sformatf("rr.grant%0d", i), 8'(grants[i]), 8'(i % 2));
      if (i > 0) chk($sformatf("rr.spacing%0d", i), 8'(gcyc[i] - gcyc[i-1]), 8'd3);
    end
    r0v = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rdy1[1] && n < 8) begin step(); @(negedge clk); n++; end
    chk("fp.req1_served_after_drop", 8'(rdy1[1]), 8'd1);
    step();
    r1v = 1'b0;
    repeat (4) step();

    // Reset during EXEC discards the op; the next tie goes to requester 0.
    do_reset();
    r0v = 1'b1; r0op = 3'd0; r0a = 4'd3; r0b = 4'd4;
    @(negedge clk);
    chk("midrst.accept", 8'(rdy0[0]), 8'd1);
    step();
    r0v = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.rsp_valid", 8'(rv[0]), 8'd0);
    chk("midrst.busy", 8'(bz[0]), 8'd0);
    chk("midrst.res", 8'(res[0]), 8'd0);
    chk("midrst.id", 8'(rid[0]), 8'd0);
    for (int i = 0; i < 3; i++) begin
      step(); @(negedge clk);
      chk("midrst.no_rsp", 8'(rv[0]), 8'd0);
    end
    step();
    r0v = 1'b1; r1v = 1'b1;
    @(negedge clk);
    chk("midrst.tie_req0", 8'(rdy0[0]), 8'd1);
    chk("midrst.tie_req1", 8'(rdy1[0]), 8'd0);
    #2 begin r0v = 1'b0; r1v = 1'b0; end
    step();

    // Randomized traffic, checked by the per-cycle compare process.
    for (int c = 0; c < 2500; c++) begin
      rst  = ($urandom_range(0, 199) == 0);
      r0v  = ($urandom_range(0, 2) != 0);
      r1v  = ($urandom_range(0, 2) != 0);
      rspr = ($urandom_range(0, 3) != 0);
      r0op = 3'($urandom); r0a = 4'($urandom); r0b = 4'($urandom);
      r1op = 3'($urandom); r1a = 4'($urandom); r1b = 4'($urandom);
      step();
    end
    rst = 1'b0; r0v = 1'b0; r1v = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
